// File: rtl/palette_param.sv
`default_nettype none
// ============================================================================
//  Module      : palette_param (package)
//  Description : Shared types and constants for the palette lookup pipeline.
//                Optional macro PALETTE_FADE_EN selects the deeper pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package palette_param;

   localparam int RGB_WIDTH = 24;

   typedef logic [RGB_WIDTH-1:0] rgb_t;

   localparam rgb_t DEFAULT_COLOR = 24'hFFFFFF;

   localparam int BASE_LATENCY = 2;
   localparam int FADE_LATENCY = 3;

`ifdef PALETTE_FADE_EN
   localparam int PIPE_LATENCY = FADE_LATENCY;
`else
   localparam int PIPE_LATENCY = BASE_LATENCY;
`endif

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/palette_ram.sv
`default_nettype none
// ============================================================================
//  Module      : palette_ram
//  Description : Single write port, registered read port with read enable;
//                a same-address read and write returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module palette_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 24
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);
   import palette_param::*;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_en) begin
         rd_data_d = mem_q[i_rd_addr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/palette_lut_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : palette_lut_pipe
//  Description : Pipelined palette lookup with runtime-writable palette RAM,
//                valid/ready handshake and reset-time RAM clear.
//                Macro PALETTE_FADE_EN adds i_fade and a fade output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module palette_lut_pipe #(
   parameter int                   NUM_PALETTES      = 16,
   parameter int                   ID_WIDTH          = 4,
   parameter int                   COLOR_WIDTH       = 4,
   parameter int                   RGB_WIDTH         = 24,
   parameter int                   TRANSPARENT_INDEX = 0,
   parameter logic [RGB_WIDTH-1:0] DEFAULT_COLOR     = palette_param::DEFAULT_COLOR
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [ID_WIDTH-1:0]    i_object_id,
   input  logic [COLOR_WIDTH-1:0] i_compressed_color,
`ifdef PALETTE_FADE_EN
   input  logic [3:0]             i_fade,
`endif
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [RGB_WIDTH-1:0]   o_color,
   output logic                   o_transparent,
   input  logic                   i_wr_en,
   input  logic [ID_WIDTH-1:0]    i_wr_palette,
   input  logic [COLOR_WIDTH-1:0] i_wr_index,
   input  logic [RGB_WIDTH-1:0]   i_wr_color,
   output logic                   o_init_done
);
   import palette_param::*;

   localparam int                     ADDR_W     = ID_WIDTH + COLOR_WIDTH;
   localparam int                     ENTRIES    = NUM_PALETTES * (2 ** COLOR_WIDTH);
   localparam logic [ADDR_W-1:0]      LAST_ADDR  = ADDR_W'(ENTRIES - 1);
   localparam logic [ID_WIDTH:0]      NUM_PAL    = (ID_WIDTH + 1)'(NUM_PALETTES);
   localparam logic [COLOR_WIDTH-1:0] TRANSP_IDX = COLOR_WIDTH'(TRANSPARENT_INDEX);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     cnt_q, cnt_d;

   logic                  ram_we, ram_re;
   logic [ADDR_W-1:0]     ram_waddr, ram_raddr;
   logic [RGB_WIDTH-1:0]  ram_wdata, ram_rdata;

   logic                  en, accept, rd_in_range, wr_in_range;
   logic [RGB_WIDTH-1:0]  s1_color;

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_oor_q, s1_oor_d;
   logic                  s1_transp_q, s1_transp_d;
   logic                  out_valid_q, out_valid_d;
   logic [RGB_WIDTH-1:0]  out_color_q, out_color_d;
   logic                  out_transp_q, out_transp_d;

   palette_ram #(
      .DEPTH  (ENTRIES),
      .ADDR_W (ADDR_W),
      .DATA_W (RGB_WIDTH)
   ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (ram_we),
      .i_wr_addr (ram_waddr),
      .i_wr_data (ram_wdata),
      .i_rd_en   (ram_re),
      .i_rd_addr (ram_raddr),
      .o_rd_data (ram_rdata)
   );

   assign rd_in_range = {1'b0, i_object_id} < NUM_PAL;
   assign wr_in_range = {1'b0, i_wr_palette} < NUM_PAL;

   // Clear walk owns the write port until RUN; user writes are ignored before then.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ram_we    = 1'b0;
      ram_waddr = cnt_q;
      ram_wdata = DEFAULT_COLOR;
      case (state_q)
         ST_INIT: begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (i_wr_en && wr_in_range) begin
               ram_we    = 1'b1;
               ram_waddr = {i_wr_palette, i_wr_index};
               ram_wdata = i_wr_color;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign en          = !out_valid_q || i_ready;
   assign o_ready     = (state_q == ST_RUN) && en;
   assign o_init_done = (state_q == ST_RUN);
   assign accept      = i_valid && o_ready;
   assign ram_re      = accept && rd_in_range;
   assign ram_raddr   = {i_object_id, i_compressed_color};
   assign s1_color    = s1_oor_q ? DEFAULT_COLOR : ram_rdata;

   always_comb begin
      s1_valid_d  = en ? accept : s1_valid_q;
      s1_oor_d    = accept ? !rd_in_range : s1_oor_q;
      s1_transp_d = accept ? (i_compressed_color == TRANSP_IDX) : s1_transp_q;
   end

`ifdef PALETTE_FADE_EN
   localparam int NUM_CH = RGB_WIDTH / 8;

   logic [3:0]           s1_fade_q, s1_fade_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [RGB_WIDTH-1:0] s2_color_q, s2_color_d;
   logic                 s2_transp_q, s2_transp_d;
   logic [3:0]           s2_fade_q, s2_fade_d;
   logic [RGB_WIDTH-1:0] faded;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_fade_ch
      logic [12:0] prod;
      assign prod                = 13'(s2_color_q[c*8 +: 8]) * (13'(s2_fade_q) + 13'd1);
      assign faded[c*8 +: 8]     = 8'(prod >> 4);
   end

   always_comb begin
      s1_fade_d    = accept ? i_fade : s1_fade_q;
      s2_valid_d   = en ? s1_valid_q : s2_valid_q;
      s2_color_d   = s2_color_q;
      s2_transp_d  = s2_transp_q;
      s2_fade_d    = s2_fade_q;
      if (en && s1_valid_q) begin
         s2_color_d  = s1_color;
         s2_transp_d = s1_transp_q;
         s2_fade_d   = s1_fade_q;
      end
      out_valid_d  = en ? s2_valid_q : out_valid_q;
      out_color_d  = out_color_q;
      out_transp_d = out_transp_q;
      if (en && s2_valid_q) begin
         out_color_d  = faded;
         out_transp_d = s2_transp_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_fade_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_color_q  <= DEFAULT_COLOR;
         s2_transp_q <= 1'b0;
         s2_fade_q   <= '0;
      end else begin
         s1_fade_q   <= s1_fade_d;
         s2_valid_q  <= s2_valid_d;
         s2_color_q  <= s2_color_d;
         s2_transp_q <= s2_transp_d;
         s2_fade_q   <= s2_fade_d;
      end
   end
`else
   always_comb begin
      out_valid_d  = en ? s1_valid_q : out_valid_q;
      out_color_d  = out_color_q;
      out_transp_d = out_transp_q;
      if (en && s1_valid_q) begin
         out_color_d  = s1_color;
         out_transp_d = s1_transp_q;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_oor_q     <= 1'b0;
         s1_transp_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_color_q  <= DEFAULT_COLOR;
         out_transp_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         s1_valid_q   <= s1_valid_d;
         s1_oor_q     <= s1_oor_d;
         s1_transp_q  <= s1_transp_d;
         out_valid_q  <= out_valid_d;
         out_color_q  <= out_color_d;
         out_transp_q <= out_transp_d;
      end
   end

   assign o_valid       = out_valid_q;
   assign o_color       = out_color_q;
   assign o_transparent = out_transp_q;

endmodule
`default_nettype wire

// File: tb/tb_palette_lut_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_lut_pipe
//  Description : Randomised scoreboard bench for palette_lut_pipe (14-palette
//                instance) plus a default-size instance for clear timing.
//                Honours PALETTE_FADE_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_lut_pipe;
   import palette_param::*;

   localparam int          NUM          = 14;
   localparam int          ENTRIES      = NUM * 16;
   localparam int          FULL_ENTRIES = 256;
   localparam int          LAT          = PIPE_LATENCY;
   localparam logic [23:0] DEF          = 24'hFFFFFF;

   logic        clk;
   logic        rst;
   logic        in_valid, out_ready, out_valid, down_ready;
   logic [3:0]  object_id, comp_color, wr_pal, wr_idx, fade;
   logic [23:0] out_color, wr_color;
   logic        out_transp, wr_en, init_done;

   logic        full_ready, full_valid, full_transp, full_init_done;
   logic [23:0] full_color;

   palette_lut_pipe #(.NUM_PALETTES(NUM)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_valid            (in_valid),
      .o_ready            (out_ready),
      .i_object_id        (object_id),
      .i_compressed_color (comp_color),
`ifdef PALETTE_FADE_EN
      .i_fade             (fade),
`endif
      .o_valid            (out_valid),
      .i_ready            (down_ready),
      .o_color            (out_color),
      .o_transparent      (out_transp),
      .i_wr_en            (wr_en),
      .i_wr_palette       (wr_pal),
      .i_wr_index         (wr_idx),
      .i_wr_color         (wr_color),
      .o_init_done        (init_done)
   );

   palette_lut_pipe dut_full (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_valid            (1'b0),
      .o_ready            (full_ready),
      .i_object_id        (4'd0),
      .i_compressed_color (4'd0),
`ifdef PALETTE_FADE_EN
      .i_fade             (4'd0),
`endif
      .o_valid            (full_valid),
      .i_ready            (1'b1),
      .o_color            (full_color),
      .o_transparent      (full_transp),
      .i_wr_en            (1'b0),
      .i_wr_palette       (4'd0),
      .i_wr_index         (4'd0),
      .i_wr_color         (24'd0),
      .o_init_done        (full_init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] color;
      logic        transp;
      int          acc;
   } exp_t;

   exp_t        q[$];
   logic [23:0] mem [16][16];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          init_left = 0;
   int          full_left = 0;
   int          last_stall = -1;
   bit          prev_stall = 0;
   bit          exp_reset = 0;
   bit          last_acc = 0;
   logic [23:0] prev_color;
   logic        prev_transp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [23:0] model_color(input logic [3:0] id, input logic [3:0] idx,
                                               input logic [3:0] f);
      logic [23:0] c;
      c = (int'(id) >= NUM) ? DEF : mem[id][idx];
`ifdef PALETTE_FADE_EN
      for (int k = 0; k < 3; k++) c[k*8 +: 8] = 8'((int'(c[k*8 +: 8]) * (int'(f) + 1)) / 16);
`else
      if (f > 4'd15) c = '0;
`endif
      return c;
   endfunction

   task automatic step(input logic r, input logic v, input logic [3:0] id, input logic [3:0] idx,
                       input logic rdy, input logic we, input logic [3:0] wp, input logic [3:0] wi,
                       input logic [23:0] wc, input logic [3:0] f);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = v; object_id = id; comp_color = idx; down_ready = rdy;
      wr_en = we; wr_pal = wp; wr_idx = wi; wr_color = wc; fade = f;
      #1;
      cyc++;
      last_acc = 0;
      if (exp_reset) begin
         check("reset_valid", out_valid, 0);
         check("reset_init_done", init_done, 0);
         check("reset_color", out_color, DEF);
         check("reset_transp", out_transp, 0);
         check("reset_full_valid", full_valid, 0);
         check("reset_full_color", full_color, DEF);
         check("reset_full_transp", full_transp, 0);
         exp_reset = 0;
      end
      if (r) begin
         q.delete();
         for (int a = 0; a < 16; a++) for (int b = 0; b < 16; b++) mem[a][b] = DEF;
         init_left  = ENTRIES;
         full_left  = FULL_ENTRIES;
         prev_stall = 0;
         exp_reset  = 1;
      end else begin
         check("init_done", init_done, init_left == 0);
         check("full_init_done", full_init_done, full_left == 0);
         check("full_ready", full_ready, full_left == 0);
         check("o_ready", out_ready, (init_left == 0) && (!out_valid || rdy));
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_color", out_color, prev_color);
            check("stall_transp", out_transp, prev_transp);
         end
         if (out_valid && rdy) begin
            if (q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               e = q.pop_front();
               check("color", out_color, e.color);
               check("transparent", out_transp, e.transp);
               if (last_stall < e.acc) check("latency", cyc - e.acc, LAT);
            end
         end
         if (v && out_ready) begin
            e.color  = model_color(id, idx, f);
            e.transp = (idx == 4'd0);
            e.acc    = cyc;
            q.push_back(e);
            last_acc = 1;
         end
         if (init_left == 0 && we && int'(wp) < NUM) mem[wp][wi] = wc;
         prev_stall  = out_valid && !rdy;
         if (prev_stall) last_stall = cyc;
         prev_color  = out_color;
         prev_transp = out_transp;
         if (init_left > 0) init_left--;
         if (full_left > 0) full_left--;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
   endtask

   task automatic lookup(input logic [3:0] id, input logic [3:0] idx, input logic [3:0] f);
      step(0, 1, id, idx, 1, 0, 0, 0, 0, f);
   endtask

   task automatic write(input logic [3:0] wp, input logic [3:0] wi, input logic [23:0] wc);
      step(0, 0, 0, 0, 1, 1, wp, wi, wc, 0);
   endtask

   initial begin
      int k;
      int t;
      rst = 1; in_valid = 0; object_id = 0; comp_color = 0; down_ready = 1;
      wr_en = 0; wr_pal = 0; wr_idx = 0; wr_color = 0; fade = 0;

      step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      idle(FULL_ENTRIES + 4);

      lookup(4'd3, 4'd5, 4'd15);
      idle(LAT + 2);

      write(4'd2, 4'd7, 24'h12AB34);
      lookup(4'd2, 4'd7, 4'd15);
      idle(LAT + 2);

      k = 0;
      t = 0;
      while (k < 8 && t < 40) begin
         step(0, 1, 4'(k + 1), 4'(k + 8), !(t >= 4 && t <= 6), 0, 0, 0, 0, 4'd15);
         if (last_acc) k++;
         t++;
      end
      check("stream_accepted", k, 8);
      idle(LAT + 2);

      write(4'd1, 4'd4, 24'h111111);
      step(0, 1, 4'd1, 4'd4, 1, 1, 4'd1, 4'd4, 24'h00FF00, 4'd15);
      lookup(4'd1, 4'd4, 4'd15);
      idle(LAT + 2);

      lookup(4'd15, 4'd0, 4'd15);
      lookup(4'd1, 4'd3, 4'd15);
      write(4'd15, 4'd3, 24'h0A0B0C);
      lookup(4'd14, 4'd3, 4'd15);
      idle(LAT + 2);

`ifdef PALETTE_FADE_EN
      write(4'd5, 4'd5, 24'hFF8040);
      lookup(4'd5, 4'd5, 4'd7);
      idle(LAT + 2);
`endif

      for (int i = 0; i < 500; i++) begin
         step(0, ($urandom % 4) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
              ($urandom % 4) != 0, ($urandom % 3) == 0, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 3)), 24'($urandom), 4'($urandom_range(0, 15)));
      end
      idle(LAT + 4);

      write(4'd2, 4'd7, 24'h12AB34);
      lookup(4'd2, 4'd7, 4'd15);
      lookup(4'd2, 4'd7, 4'd15);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      idle(FULL_ENTRIES + 4);
      lookup(4'd2, 4'd7, 4'd15);
      idle(2 * LAT + 4);
      check("drain_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
